// File: rtl/emu_dmem_pkg.sv
// Shared encodings for the emulation-platform data memory controller:
// RV32 load/store funct3 values, response error codes and FSM states.
package emu_dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/emu_dmem_array.sv
// Single-port synchronous 32-bit word array with byte enables.
// Read data is registered on en & !we and holds otherwise.
module emu_dmem_array #(
    parameter int unsigned DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [0:(1 << DEPTH_LOG2)-1];
    logic [31:0] rdata_q;

    // No reset: contents must survive a controller reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/emu_dmem_ctrl.sv
// RV32 load/store data memory controller: valid/ready request and response,
// fault decode, configurable latency, lane shifting and sign extension.
module emu_dmem_ctrl
    import emu_dmem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err
);

    localparam bit         HAS_WAIT = (LATENCY > 1);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            alo_q, alo_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            err_q, err_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [1:0]            err_new;
    logic                  arr_en;
    logic [3:0]            arr_be;
    logic [31:0]           arr_wdata;
    logic [31:0]           arr_rdata;
    logic [31:0]           lane;
    logic [31:0]           ext;

    // Offset wraps modulo 2**ADDR_WIDTH, so addresses below BASE_ADDR land out of range.
    assign off = req_addr - BASE_ADDR;

    always_comb begin
        err_new = ERR_OK;
        if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
            (((req_funct3 == F3_BU) || (req_funct3 == F3_HU)) && req_we)) begin
            err_new = ERR_ILLEGAL;
        end else if ((((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))) begin
            err_new = ERR_MISALIGN;
        end else if (|(off >> (DEPTH_LOG2 + 2))) begin
            err_new = ERR_RANGE;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        f3_d       = f3_q;
        alo_d      = alo_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        arr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    alo_d   = req_addr[1:0];
                    idx_d   = off[DEPTH_LOG2+1:2];
                    wdata_d = req_wdata;
                    err_d   = err_new;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                arr_en = (err_q == ERR_OK);
                if (HAS_WAIT) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            alo_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (f3_q)
            F3_B:    arr_be = 4'b0001 << alo_q;
            F3_H:    arr_be = 4'b0011 << alo_q;
            default: arr_be = 4'b1111;
        endcase
    end

    assign arr_wdata = wdata_q << {alo_q, 3'b000};

    emu_dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (we_q),
        .be   (arr_be),
        .idx  (idx_q),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    assign lane = arr_rdata >> {alo_q, 3'b000};

    always_comb begin
        case (f3_q)
            F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
            F3_W:    ext = lane;
            F3_BU:   ext = {24'd0, lane[7:0]};
            F3_HU:   ext = {16'd0, lane[15:0]};
            default: ext = '0;
        endcase
    end

    // Response fields derive only from registered state, so they hold until the handshake.
    always_comb begin
        resp_rdata = '0;
        resp_err   = ERR_OK;
        if (state_q == S_RESP) begin
            resp_err = err_q;
            if (!we_q && (err_q == ERR_OK)) begin
                resp_rdata = ext;
            end
        end
    end

endmodule

// File: tb/tb_emu_dmem_ctrl.sv
// Directed bench for emu_dmem_ctrl: a scoreboard queue holds the expected
// response of each request and is popped when the response appears.
module tb_emu_dmem_ctrl;

    localparam int unsigned LAT = 3;

    localparam logic [2:0] TB_B  = 3'b000;
    localparam logic [2:0] TB_H  = 3'b001;
    localparam logic [2:0] TB_W  = 3'b010;
    localparam logic [2:0] TB_BU = 3'b100;
    localparam logic [2:0] TB_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    emu_dmem_ctrl #(
        .ADDR_WIDTH(32),
        .DEPTH_LOG2(16),
        .BASE_ADDR (32'h8000_0000),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata, 32'd0);
        check({tag, " resp_err"}, 32'(resp_err), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    // Full transaction: accept, measure latency, compare against the scoreboard,
    // optionally stall the response for `hold` cycles, then complete the handshake.
    task automatic send(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input int unsigned hold);
        exp_t        e;
        exp_t        got;
        int unsigned n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        wait_ready(tag);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (resp_valid !== 1'b1 && n < 20);
        check({tag, " latency"}, n, LAT);
        got = sb_q.pop_front();
        check({tag, " rdata"}, resp_rdata, got.rdata);
        check({tag, " err"}, 32'(resp_err), 32'(got.err));
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold ready"}, 32'(req_ready), 32'd0);
            check({tag, " hold rdata"}, resp_rdata, got.rdata);
            check({tag, " hold err"}, 32'(resp_err), 32'(got.err));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = TB_W;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        // T1 word store/load
        send("t1_sw", 1'b1, TB_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 2'b00, 0);
        send("t1_lw", 1'b0, TB_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2'b00, 0);

        // T2 byte/half extraction and extension
        send("t2_lb13",  1'b0, TB_B,  32'h8000_0013, 32'h0, 32'hFFFF_FFDE, 2'b00, 0);
        send("t2_lbu13", 1'b0, TB_BU, 32'h8000_0013, 32'h0, 32'h0000_00DE, 2'b00, 0);
        send("t2_lh12",  1'b0, TB_H,  32'h8000_0012, 32'h0, 32'hFFFF_DEAD, 2'b00, 0);
        send("t2_lhu10", 1'b0, TB_HU, 32'h8000_0010, 32'h0, 32'h0000_BEEF, 2'b00, 0);
        send("t2_lb10",  1'b0, TB_B,  32'h8000_0010, 32'h0, 32'hFFFF_FFEF, 2'b00, 0);
        send("t2_lbu11", 1'b0, TB_BU, 32'h8000_0011, 32'h0, 32'h0000_00BE, 2'b00, 0);

        // T3 byte and half stores touch only their lanes
        send("t3_sb11", 1'b1, TB_B, 32'h8000_0011, 32'hFFFF_FF55, 32'h0, 2'b00, 0);
        send("t3_lw",   1'b0, TB_W, 32'h8000_0010, 32'h0, 32'hDEAD_55EF, 2'b00, 0);
        send("t3_sh12", 1'b1, TB_H, 32'h8000_0012, 32'hABCD_1234, 32'h0, 2'b00, 0);
        send("t3_lw2",  1'b0, TB_W, 32'h8000_0010, 32'h0, 32'h1234_55EF, 2'b00, 0);

        // T4 faults and range boundaries
        send("t4_sw0",    1'b1, TB_W, 32'h8000_0000, 32'h0BAD_F00D, 32'h0, 2'b00, 0);
        send("t4_swtop",  1'b1, TB_W, 32'h8003_FFFC, 32'h7777_1234, 32'h0, 2'b00, 0);
        send("t4_lwtop",  1'b0, TB_W, 32'h8003_FFFC, 32'h0, 32'h7777_1234, 2'b00, 0);
        send("t4_lwmis",  1'b0, TB_W, 32'h8000_0012, 32'h0, 32'h0, 2'b01, 0);
        send("t4_lhmis",  1'b0, TB_H, 32'h8000_0011, 32'h0, 32'h0, 2'b01, 0);
        send("t4_swoor",  1'b1, TB_W, 32'h8004_0000, 32'hFFFF_FFFF, 32'h0, 2'b10, 0);
        send("t4_lw0",    1'b0, TB_W, 32'h8000_0000, 32'h0, 32'h0BAD_F00D, 2'b00, 0);
        send("t4_below",  1'b0, TB_W, 32'h7FFF_FFFC, 32'h0, 32'h0, 2'b10, 0);
        send("t4_f011",   1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 2'b11, 0);
        send("t4_sbu",    1'b1, TB_BU, 32'h8000_0010, 32'h0, 32'h0, 2'b11, 0);
        send("t4_shu",    1'b1, TB_HU, 32'h8000_0010, 32'h0, 32'h0, 2'b11, 0);
        send("t4_prio1",  1'b0, 3'b111, 32'h8004_0001, 32'h0, 32'h0, 2'b11, 0);
        send("t4_prio2",  1'b0, TB_HU, 32'h8004_0001, 32'h0, 32'h0, 2'b01, 0);
        send("t4_lw_chk", 1'b0, TB_W, 32'h8000_0010, 32'h0, 32'h1234_55EF, 2'b00, 0);

        // T5 backpressure on the response
        send("t5_bp", 1'b0, TB_W, 32'h8000_0010, 32'h0, 32'h1234_55EF, 2'b00, 5);

        // Reset before the access edge: store must not happen
        send("t6_pre", 1'b1, TB_W, 32'h8000_0024, 32'h1111_1111, 32'h0, 2'b00, 0);
        wait_ready("t6_early");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = TB_W;
        req_addr   = 32'h8000_0024;
        req_wdata  = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        check_reset_outputs("t6_early_rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        send("t6_early_lw", 1'b0, TB_W, 32'h8000_0024, 32'h0, 32'h1111_1111, 2'b00, 0);

        // T6 reset after the access edge: store has completed
        wait_ready("t6_late");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = TB_W;
        req_addr   = 32'h8000_0020;
        req_wdata  = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_late_novalid", 32'(resp_valid), 32'd0);
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_late_rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        send("t6_late_lw", 1'b0, TB_W, 32'h8000_0020, 32'h0, 32'h1234_5678, 2'b00, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
